// File: rtl/jaa_pkg.sv
// Shared Java bytecode constants for the fetch unit and the translator.
// Opcode values, fetch FSM encoding and operand-count codes.
package jaa_pkg;

    localparam logic [7:0] OP_NOP      = 8'h00;
    localparam logic [7:0] OP_ICONST_0 = 8'h03;
    localparam logic [7:0] OP_ICONST_5 = 8'h08;
    localparam logic [7:0] OP_BIPUSH   = 8'h10;
    localparam logic [7:0] OP_SIPUSH   = 8'h11;
    localparam logic [7:0] OP_ILOAD    = 8'h15;
    localparam logic [7:0] OP_ILOAD_0  = 8'h1A;
    localparam logic [7:0] OP_ILOAD_3  = 8'h1D;
    localparam logic [7:0] OP_ISTORE   = 8'h36;
    localparam logic [7:0] OP_ISTORE_0 = 8'h3B;
    localparam logic [7:0] OP_ISTORE_3 = 8'h3E;
    localparam logic [7:0] OP_IADD     = 8'h60;
    localparam logic [7:0] OP_ISUB     = 8'h64;
    localparam logic [7:0] OP_IINC     = 8'h84;
    localparam logic [7:0] OP_GOTO     = 8'hA7;

    localparam logic [1:0] NOPS_0 = 2'd0;
    localparam logic [1:0] NOPS_1 = 2'd1;
    localparam logic [1:0] NOPS_2 = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_LAT  = 3'd2,
        ST_EMIT = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/jbc_fetch_if.sv
// ROM read port and bytecode bundle handshake of the fetch unit.
// master = fetch unit side, slave = ROM / translator side.
interface jbc_fetch_if #(
    parameter int ADDR_W = 10
);
    logic              rom_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_data;
    logic              bc_valid;
    logic              bc_ready;
    logic [7:0]        bc_opcode;
    logic [7:0]        bc_op1;
    logic [7:0]        bc_op2;
    logic [1:0]        bc_nops;
    logic [ADDR_W-1:0] bc_pc;
    logic              bc_illegal;

    modport master (
        output rom_en, rom_addr,
        input  rom_data,
        output bc_valid, bc_opcode, bc_op1, bc_op2,
        output bc_nops, bc_pc, bc_illegal,
        input  bc_ready
    );

    modport slave (
        input  rom_en, rom_addr,
        output rom_data,
        input  bc_valid, bc_opcode, bc_op1, bc_op2,
        input  bc_nops, bc_pc, bc_illegal,
        output bc_ready
    );
endinterface

// File: rtl/jbc_len_decode.sv
// Opcode length classifier: operand count and illegal flag.
// Purely combinational so the translator can reuse it as a cross-check.
module jbc_len_decode
    import jaa_pkg::*;
(
    input  logic [7:0] i_opcode,
    output logic [1:0] o_nops,
    output logic       o_illegal
);
    logic w_zero;
    logic w_one;
    logic w_two;

    assign w_zero = (i_opcode == OP_NOP)
        || (i_opcode >= OP_ICONST_0 && i_opcode <= OP_ICONST_5)
        || (i_opcode >= OP_ILOAD_0 && i_opcode <= OP_ILOAD_3)
        || (i_opcode >= OP_ISTORE_0 && i_opcode <= OP_ISTORE_3)
        || (i_opcode == OP_IADD)
        || (i_opcode == OP_ISUB);

    assign w_one = (i_opcode == OP_BIPUSH)
        || (i_opcode == OP_ILOAD)
        || (i_opcode == OP_ISTORE);

    assign w_two = (i_opcode == OP_SIPUSH)
        || (i_opcode == OP_IINC)
        || (i_opcode == OP_GOTO);

    // map the class flags onto the operand count, unknowns are illegal
    always_comb begin
        o_nops    = NOPS_0;
        o_illegal = 1'b0;
        unique case (1'b1)
            w_zero:  o_nops = NOPS_0;
            w_one:   o_nops = NOPS_1;
            w_two:   o_nops = NOPS_2;
            default: o_illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/jbc_fetch.sv
// Bytecode fetch: reads opcode and operand bytes from a synchronous ROM
// and hands one complete bytecode per valid/ready handshake downstream.
module jbc_fetch
    import jaa_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [ADDR_W:0] prog_len,
    output logic            done,
    output logic            err_trunc,
    jbc_fetch_if.master     bus
);
    localparam logic [ADDR_W:0] PC_ONE = 1;

    state_t            r_state;
    logic [ADDR_W:0]   r_pc;
    logic [ADDR_W:0]   r_len;
    logic [1:0]        r_k;
    logic              r_rom_en;
    logic [ADDR_W-1:0] r_rom_addr;
    logic              r_valid;
    logic [7:0]        r_opc;
    logic [7:0]        r_op1;
    logic [7:0]        r_op2;
    logic [1:0]        r_nops;
    logic [ADDR_W-1:0] r_bc_pc;
    logic              r_ill;
    logic              r_done;
    logic              r_trunc;

    logic [1:0]        w_dec_nops;
    logic              w_dec_ill;
    logic [ADDR_W:0]   w_pc_nxt;
    logic              w_need;

    jbc_len_decode u_len (
        .i_opcode  (bus.rom_data),
        .o_nops    (w_dec_nops),
        .o_illegal (w_dec_ill)
    );

    assign w_pc_nxt = r_pc + PC_ONE;

    // after this LAT, does the current bytecode still need operand bytes
    always_comb begin
        w_need = 1'b0;
        if (r_k == 2'd0) begin
            w_need = (w_dec_nops != NOPS_0);
        end else begin
            w_need = (r_k < r_nops);
        end
    end

    // fetch FSM with all outputs registered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_pc       <= '0;
            r_len      <= '0;
            r_k        <= 2'd0;
            r_rom_en   <= 1'b0;
            r_rom_addr <= '0;
            r_valid    <= 1'b0;
            r_opc      <= 8'h00;
            r_op1      <= 8'h00;
            r_op2      <= 8'h00;
            r_nops     <= NOPS_0;
            r_bc_pc    <= '0;
            r_ill      <= 1'b0;
            r_done     <= 1'b0;
            r_trunc    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_pc    <= '0;
                        r_len   <= prog_len;
                        r_trunc <= 1'b0;
                        r_k     <= 2'd0;
                        if (prog_len != '0) begin
                            r_state    <= ST_REQ;
                            r_rom_en   <= 1'b1;
                            r_rom_addr <= '0;
                            r_done     <= 1'b0;
                        end else begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    r_rom_en <= 1'b0;
                    r_state  <= ST_LAT;
                end
                ST_LAT: begin
                    r_pc <= w_pc_nxt;
                    if (r_k == 2'd0) begin
                        r_opc   <= bus.rom_data;
                        r_op1   <= 8'h00;
                        r_op2   <= 8'h00;
                        r_nops  <= w_dec_nops;
                        r_ill   <= w_dec_ill;
                        r_bc_pc <= r_pc[ADDR_W-1:0];
                    end else if (r_k == 2'd1) begin
                        r_op1 <= bus.rom_data;
                    end else begin
                        r_op2 <= bus.rom_data;
                    end
                    if (w_need) begin
                        if (w_pc_nxt < r_len) begin
                            r_state    <= ST_REQ;
                            r_rom_en   <= 1'b1;
                            r_rom_addr <= w_pc_nxt[ADDR_W-1:0];
                            r_k        <= r_k + 2'd1;
                        end else begin
                            r_state <= ST_DONE;
                            r_trunc <= 1'b1;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_state <= ST_EMIT;
                        r_valid <= 1'b1;
                    end
                end
                ST_EMIT: begin
                    if (bus.bc_ready) begin
                        r_valid <= 1'b0;
                        r_k     <= 2'd0;
                        if (r_pc == r_len) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state    <= ST_REQ;
                            r_rom_en   <= 1'b1;
                            r_rom_addr <= r_pc[ADDR_W-1:0];
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.rom_en     = r_rom_en;
    assign bus.rom_addr   = r_rom_addr;
    assign bus.bc_valid   = r_valid;
    assign bus.bc_opcode  = r_opc;
    assign bus.bc_op1     = r_op1;
    assign bus.bc_op2     = r_op2;
    assign bus.bc_nops    = r_nops;
    assign bus.bc_pc      = r_bc_pc;
    assign bus.bc_illegal = r_ill;
    assign done           = r_done;
    assign err_trunc      = r_trunc;
endmodule

// File: doc/jbc_fetch.md
# jbc_fetch

Bytecode fetch and operand assembler that sits directly upstream of the Java-to-ARM translator. It walks a byte-wide synchronous program ROM from address 0 and classifies each Java opcode by operand count (0, 1 or 2). It collects the operand bytes and presents one complete bytecode per valid/ready handshake. This replaces the free-running byte-per-clock feed, so the translator never samples a byte that is mid-instruction.

## Interface
Parameters:
- ADDR_W, 10, ROM address width; the program is at most 2^ADDR_W bytes.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  level; sampled only in IDLE and DONE; begins a fetch run at pc=0.
- prog_len  in  ADDR_W+1  program length in bytes; sampled on start.
- rom_en  out  1  ROM read strobe.
- rom_addr  out  ADDR_W  ROM byte address.
- rom_data  in  8  ROM byte, valid the cycle after rom_en=1.
- bc_valid  out  1  bytecode bundle available.
- bc_ready  in  1  translator accepts the bundle.
- bc_opcode  out  8  Java opcode.
- bc_op1, bc_op2  out  8 each  operand bytes; 0 if unused.
- bc_nops  out  2  operand count, 0..2.
- bc_pc  out  ADDR_W  address of the opcode byte.
- bc_illegal  out  1  opcode is not in the length table.
- done  out  1  run finished; high in DONE.
- err_trunc  out  1  sticky; program ended mid-instruction.

## Operation
- Length table:
  - 0 operands: 0x00 nop, 0x03–0x08 iconst_0..5, 0x1A–0x1D iload_0..3, 0x3B–0x3E istore_0..3, 0x60 iadd, 0x64 isub.
  - 1 operand: 0x10 bipush, 0x15 iload, 0x36 istore.
  - 2 operands: 0x11 sipush, 0x84 iinc, 0xA7 goto.
  - Any other opcode: bc_illegal=1, bc_nops=0; it is emitted and the fetch continues.
- States:
  - IDLE: on start, pc←0, latch prog_len, clear err_trunc; go to REQ if prog_len≠0, else DONE.
  - REQ: rom_en=1, rom_addr=pc; go to LAT.
  - LAT: capture rom_data into opcode or operand slot k, pc←pc+1. Then:
    - if more operands are needed and pc+1 < prog_len, go to REQ;
    - if more operands are needed and pc+1 ≥ prog_len, set err_trunc and go to DONE (no emit);
    - otherwise go to EMIT.
  - EMIT: bc_valid=1 with all bc_* outputs stable until bc_ready. On handshake, go to DONE if pc==prog_len, else go to REQ.
  - DONE: done=1; start restarts the run exactly as from IDLE.
- Operand slots are cleared to 0 at every opcode capture.
- pc is ADDR_W+1 bits so the compare against prog_len never wraps.

## Timing
- Reset values: state IDLE, pc 0, rom_en 0, rom_addr 0, bc_valid 0, all bc_* outputs 0, done 0, err_trunc 0.
- For a start sampled at edge E0, REQ is active in cycle E0..E1.
- For a 0-operand opcode, bc_valid rises after E2.
- Each operand byte adds 2 cycles.
- With bc_ready tied high, the cost per bytecode is 3+2·nops cycles including the EMIT cycle.
- bc_valid never drops before the handshake; bc_ready is ignored outside EMIT.
- rom_en is high only in REQ; there is never more than one outstanding read.
- start asserted outside IDLE/DONE is ignored.
- Reset asserted mid-run aborts immediately to reset values. Any partially assembled bundle is discarded, and the translator must not see a handshake completed during reset.

## Structure
- Shared package jaa_pkg holds:
  - opcode localparams (the same values the translator decodes);
  - the state encoding;
  - the NOPS_0/1/2 constants.
- Sub-module jbc_len_decode is combinational: opcode → {nops[1:0], illegal}. The translator reuses it to cross-check bc_nops.

## Test plan
- ROM = 03 3C 1B 60, prog_len=4, bc_ready=1 → four bundles in order (03/0, 3C/0, 1B/0, 60/0) with bc_pc 0,1,2,3; each bc_valid is 3 cycles after the previous handshake; done after the fourth.
- ROM = 10 7F 11 01 2C, prog_len=5 → bundle 10 with op1=7F, nops=1, pc=0; then 11 with op1=01, op2=2C, nops=2, pc=2; second bc_valid 7 cycles after the first handshake.
- Same ROM as the first test, bc_ready low for 5 cycles in EMIT → bc_valid and all bc_* outputs held constant; exactly one bundle accepted when ready rises.
- ROM = 84 01, prog_len=2 → no bundle emitted; err_trunc=1; done=1; a second start with prog_len=1 on ROM=00 clears err_trunc and emits nop.
- ROM = FE 03, prog_len=2 → FE emitted with bc_illegal=1, nops=0; then 03 emitted normally.
- Reset pulse asserted in LAT of an operand fetch → bc_valid, done and rom_en low immediately; after release and start, fetch restarts at pc=0.
